// File: rtl/fcs_pkg.sv
// Shared types and constants for the CRC-16 FCS transmit path.
package fcs_pkg;

    localparam int FCS_WIDTH  = 16;
    localparam int BYTE_WIDTH = 8;

    // Remainder of "123456789" and of the single byte 0x01 (the generator itself).
    localparam logic [FCS_WIDTH-1:0] FCS_CHECK_123456789 = 16'h31C3;
    localparam logic [FCS_WIDTH-1:0] FCS_POLY            = 16'h1021;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_FCS,
        ST_GAP
    } tx_state_e;

endpackage

// File: rtl/fcs_gap_timer.sv
// Loadable down-counter timing the inter-frame gap; done_o is high on the last gap cycle.
module fcs_gap_timer #(
    parameter int COUNT = 12
) (
    input  logic CLK,
    input  logic RST,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int CW = (COUNT < 2) ? 1 : $clog2(COUNT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CW'(COUNT - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/fcs_frame_tx_ctrl.sv
// Transmit sequencer for the serial CRC-16 FCS engine: serialises payload bytes MSB-first,
// appends the engine remainder and enforces an inter-frame gap.
//   state | meaning
//   IDLE  | ready for the first byte of a frame
//   DATA  | shifting payload bits to line and engine
//   WAIT  | source underrun, engine holding
//   FCS   | shifting the held remainder to line
//   GAP   | engine cleared, inter-frame idle
module fcs_frame_tx_ctrl
    import fcs_pkg::*;
#(
    parameter int MAX_BYTES  = 256,
    parameter int LEN_WIDTH  = 9,
    parameter int IFG_CYCLES = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [BYTE_WIDTH-1:0] Data_In,
    input  logic                  Data_Valid,
    input  logic                  Data_Last,
    output logic                  Data_Ready,
    input  logic [FCS_WIDTH-1:0]  FCS_In,
    output logic                  FCS_Enable,
    output logic                  FCS_Data,
    output logic                  FCS_Cnt_done,
    output logic                  Ser_Out,
    output logic                  Ser_Valid,
    output logic                  Frame_Done,
    output logic [FCS_WIDTH-1:0]  Frame_Fcs,
    output logic [LEN_WIDTH-1:0]  Frame_Len,
    output logic                  Frame_Trunc
);

    localparam logic [LEN_WIDTH-1:0] MAX_CNT = LEN_WIDTH'(MAX_BYTES);

    tx_state_e             state_q, state_d;
    logic [BYTE_WIDTH-1:0] shreg_q, shreg_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [3:0]            fcs_cnt_q, fcs_cnt_d;
    logic [LEN_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
    logic                  last_q, last_d;
    logic                  trunc_q, trunc_d;
    logic [FCS_WIDTH-1:0]  frame_fcs_q, frame_fcs_d;
    logic [LEN_WIDTH-1:0]  frame_len_q, frame_len_d;
    logic                  frame_trunc_q, frame_trunc_d;
    logic                  frame_done_q, frame_done_d;

    logic [LEN_WIDTH-1:0]  byte_cnt_inc;
    logic                  at_max;
    logic                  accept;
    logic                  gap_load;
    logic                  gap_done;

    // The count left over in IDLE belongs to the previous frame, so a fresh frame restarts at 1.
    assign byte_cnt_inc = (state_q == ST_IDLE) ? LEN_WIDTH'(1) : byte_cnt_q + LEN_WIDTH'(1);
    assign at_max       = (byte_cnt_inc == MAX_CNT);

    fcs_gap_timer #(
        .COUNT (IFG_CYCLES)
    ) u_gap_timer (
        .CLK    (CLK),
        .RST    (RST),
        .load_i (gap_load),
        .en_i   (state_q == ST_GAP),
        .done_o (gap_done)
    );

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        fcs_cnt_d     = fcs_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        last_d        = last_q;
        trunc_d       = trunc_q;
        frame_fcs_d   = frame_fcs_q;
        frame_len_d   = frame_len_q;
        frame_trunc_d = frame_trunc_q;
        frame_done_d  = 1'b0;
        gap_load      = 1'b0;
        Data_Ready    = 1'b0;
        FCS_Enable    = 1'b0;
        FCS_Data      = 1'b0;
        FCS_Cnt_done  = 1'b0;
        Ser_Out       = 1'b0;
        Ser_Valid     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                Data_Ready = 1'b1;
            end
            ST_DATA: begin
                Ser_Out    = shreg_q[BYTE_WIDTH-1];
                FCS_Data   = shreg_q[BYTE_WIDTH-1];
                Ser_Valid  = 1'b1;
                FCS_Enable = 1'b1;
                shreg_d    = {shreg_q[BYTE_WIDTH-2:0], 1'b0};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    Data_Ready = !last_q;
                    if (last_q) begin
                        state_d   = ST_FCS;
                        fcs_cnt_d = 4'd0;
                    end else if (!Data_Valid) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                Data_Ready   = 1'b1;
                FCS_Enable   = 1'b1;
                FCS_Cnt_done = 1'b1;
            end
            ST_FCS: begin
                FCS_Enable   = 1'b1;
                FCS_Cnt_done = 1'b1;
                Ser_Valid    = 1'b1;
                Ser_Out      = FCS_In[4'd15 - fcs_cnt_q];
                fcs_cnt_d    = fcs_cnt_q + 4'd1;
                if (fcs_cnt_q == 4'd15) begin
                    state_d       = ST_GAP;
                    gap_load      = 1'b1;
                    frame_fcs_d   = FCS_In;
                    frame_len_d   = byte_cnt_q;
                    frame_trunc_d = trunc_q;
                    frame_done_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Nothing may be taken from the source while reset is held.
        if (RST) begin
            Data_Ready = 1'b0;
        end

        accept = Data_Valid && Data_Ready;
        if (accept) begin
            state_d    = ST_DATA;
            shreg_d    = Data_In;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = byte_cnt_inc;
            last_d     = Data_Last || at_max;
            trunc_d    = at_max && !Data_Last;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            fcs_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            last_q        <= 1'b0;
            trunc_q       <= 1'b0;
            frame_fcs_q   <= '0;
            frame_len_q   <= '0;
            frame_trunc_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            fcs_cnt_q     <= fcs_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            last_q        <= last_d;
            trunc_q       <= trunc_d;
            frame_fcs_q   <= frame_fcs_d;
            frame_len_q   <= frame_len_d;
            frame_trunc_q <= frame_trunc_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign Frame_Done  = frame_done_q;
    assign Frame_Fcs   = frame_fcs_q;
    assign Frame_Len   = frame_len_q;
    assign Frame_Trunc = frame_trunc_q;

endmodule

// File: tb/tb_fcs_frame_tx_ctrl.sv
// Bench for fcs_frame_tx_ctrl: drives byte frames, models the sibling FCS engine, and checks
// the serial stream and frame reports against a byte-level CRC and framing model.
module tb_fcs_frame_tx_ctrl;

   localparam int MAXB = 10;
   localparam int LW   = 4;
   localparam int IFG  = 12;

   logic          CLK;
   logic          RST;
   logic [7:0]    Data_In;
   logic          Data_Valid;
   logic          Data_Last;
   logic          Data_Ready;
   logic [15:0]   FCS_In;
   logic          FCS_Enable;
   logic          FCS_Data;
   logic          FCS_Cnt_done;
   logic          Ser_Out;
   logic          Ser_Valid;
   logic          Frame_Done;
   logic [15:0]   Frame_Fcs;
   logic [LW-1:0] Frame_Len;
   logic          Frame_Trunc;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int done_cnt    = 0;

   fcs_frame_tx_ctrl #(
      .MAX_BYTES  (MAXB),
      .LEN_WIDTH  (LW),
      .IFG_CYCLES (IFG)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .Data_In      (Data_In),
      .Data_Valid   (Data_Valid),
      .Data_Last    (Data_Last),
      .Data_Ready   (Data_Ready),
      .FCS_In       (FCS_In),
      .FCS_Enable   (FCS_Enable),
      .FCS_Data     (FCS_Data),
      .FCS_Cnt_done (FCS_Cnt_done),
      .Ser_Out      (Ser_Out),
      .Ser_Valid    (Ser_Valid),
      .Frame_Done   (Frame_Done),
      .Frame_Fcs    (Frame_Fcs),
      .Frame_Len    (Frame_Len),
      .Frame_Trunc  (Frame_Trunc)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input bit ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $error("FAIL %s", tag);
      end
   endtask

   // Sibling serial CRC engine driven by the DUT's control outputs.
   logic [15:0] eng = 16'h0000;
   always @(posedge CLK) begin
      if (!FCS_Enable)
         eng <= 16'h0000;
      else if (!FCS_Cnt_done)
         eng <= {eng[14:0], 1'b0} ^ ((eng[15] ^ FCS_Data) ? 16'h1021 : 16'h0000);
   end
   assign FCS_In = eng;

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++)
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   // Reference model state: expected line bits and pending frame reports.
   logic          exp_bits[$];
   logic [15:0]   exp_fcs[$];
   logic [LW-1:0] exp_len[$];
   logic          exp_trunc[$];
   int            exp_done[$];
   logic [15:0]   h_fcs[$];
   logic [LW-1:0] h_len[$];
   logic          h_trunc[$];
   int            h_cyc[$];
   logic [15:0]   crc_acc = 16'h0000;
   int            cur_n = 0;
   int            close_cyc = 0;
   bit            have_close = 0;

   always @(negedge CLK) begin
      logic          eb;
      logic [15:0]   ef;
      logic [LW-1:0] el;
      logic          et;
      int            ec;
      if (RST) begin
         exp_bits.delete();
         exp_fcs.delete();
         exp_len.delete();
         exp_trunc.delete();
         exp_done.delete();
         cur_n      = 0;
         crc_acc    = 16'h0000;
         have_close = 0;
      end else begin
         if (Ser_Valid) begin
            chk("ser_pending", exp_bits.size() > 0);
            if (exp_bits.size() > 0) begin
               eb = exp_bits.pop_front();
               chk("ser_bit", Ser_Out === eb);
            end
         end
         if (Frame_Done) begin
            chk("done_expected", exp_fcs.size() > 0);
            if (exp_fcs.size() > 0) begin
               ef = exp_fcs.pop_front();
               el = exp_len.pop_front();
               et = exp_trunc.pop_front();
               ec = exp_done.pop_front();
               chk("frame_fcs", Frame_Fcs === ef);
               chk("frame_len", Frame_Len === el);
               chk("frame_trunc", Frame_Trunc === et);
               chk("done_cycle", cyc == ec);
            end
            h_fcs.push_back(Frame_Fcs);
            h_len.push_back(Frame_Len);
            h_trunc.push_back(Frame_Trunc);
            h_cyc.push_back(cyc);
            done_cnt++;
         end
         if (have_close && cyc > close_cyc && cyc <= close_cyc + 24 + IFG)
            chk("ready_blocked", Data_Ready === 1'b0);
         if (have_close && cyc > close_cyc + 24 && cyc <= close_cyc + 24 + IFG)
            chk("gap_ser_valid", Ser_Valid === 1'b0);
         if (have_close && cyc == close_cyc + 25 + IFG)
            chk("ready_after_gap", Data_Ready === 1'b1);
         if (Data_Valid && Data_Ready) begin
            for (int i = 7; i >= 0; i--) exp_bits.push_back(Data_In[i]);
            crc_acc = crc_byte(crc_acc, Data_In);
            cur_n++;
            if (Data_Last || cur_n == MAXB) begin
               for (int i = 15; i >= 0; i--) exp_bits.push_back(crc_acc[i]);
               exp_fcs.push_back(crc_acc);
               exp_len.push_back(LW'(cur_n));
               exp_trunc.push_back(!Data_Last);
               exp_done.push_back(cyc + 25);
               close_cyc  = cyc;
               have_close = 1;
               cur_n      = 0;
               crc_acc    = 16'h0000;
            end
         end
      end
   end

   logic [7:0] fb[$];
   logic       fl[$];
   int         fg[$];
   int         acc_q[$];

   task automatic put_byte(input logic [7:0] b, input logic last, input int gap, output int acc);
      int n;
      if (gap > 0) begin
         Data_Valid = 1'b0;
         repeat (gap) @(posedge CLK);
         #1;
      end
      Data_In    = b;
      Data_Last  = last;
      Data_Valid = 1'b1;
      n = 0;
      @(negedge CLK);
      while (!Data_Ready && n < 300) begin
         @(negedge CLK);
         n++;
      end
      acc = cyc;
      chk("accept_timeout", n < 300);
      @(posedge CLK);
      #1;
   endtask

   task automatic send_queued();
      int a;
      acc_q.delete();
      for (int i = 0; i < fb.size(); i++) begin
         put_byte(fb[i], fl[i], fg[i], a);
         acc_q.push_back(a);
      end
      Data_Valid = 1'b0;
      Data_Last  = 1'b0;
      fb.delete();
      fl.delete();
      fg.delete();
   endtask

   task automatic q_byte(input logic [7:0] b, input logic last, input int gap);
      fb.push_back(b);
      fl.push_back(last);
      fg.push_back(gap);
   endtask

   task automatic q_check_string(input int gap_before_5th);
      for (int i = 0; i < 9; i++)
         q_byte(8'h31 + 8'(i), (i == 8), (i == 4) ? gap_before_5th : 0);
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 600) begin
         @(negedge CLK);
         n++;
      end
      chk("done_timeout", done_cnt >= target);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int n;
      int len;
      bit lst;
      RST        = 1'b1;
      Data_In    = 8'h00;
      Data_Valid = 1'b0;
      Data_Last  = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("reset_outputs", {Data_Ready, FCS_Enable, FCS_Data, FCS_Cnt_done, Ser_Out, Ser_Valid,
                            Frame_Done, Frame_Fcs, Frame_Len, Frame_Trunc} === 28'h0);
      @(posedge CLK);
      #1 RST = 1'b0;

      // "123456789" back-to-back.
      q_check_string(0);
      send_queued();
      wait_done(1);
      chk("t1_fcs", h_fcs[0] === 16'h31C3);
      chk("t1_len", h_len[0] === 4'd9);
      chk("t1_trunc", h_trunc[0] === 1'b0);
      chk("t1_latency", (h_cyc[0] - acc_q[0]) == 89);

      // Single byte frame.
      q_byte(8'h01, 1'b1, 0);
      send_queued();
      wait_done(2);
      chk("t2_fcs", h_fcs[1] === 16'h1021);
      chk("t2_len", h_len[1] === 4'd1);

      // Source stalls after byte 4: valid low 12 cycles gives 5 underrun cycles.
      q_check_string(12);
      send_queued();
      wait_done(3);
      chk("t3_fcs", h_fcs[2] === 16'h31C3);
      chk("t3_latency", (h_cyc[2] - acc_q[0]) == (8 * 9 + 17 + 5));

      // Twelve zero bytes without last: first frame truncates at MAXB, rest held for the next.
      for (int i = 0; i < 12; i++) q_byte(8'h00, 1'b0, 0);
      q_byte(8'h5A, 1'b1, 0);
      send_queued();
      wait_done(5);
      chk("t4_fcs", h_fcs[3] === 16'h0000);
      chk("t4_len", h_len[3] === 4'd10);
      chk("t4_trunc", h_trunc[3] === 1'b1);
      chk("t4_held_byte", (acc_q[10] - acc_q[9]) == (25 + IFG));
      chk("t4_next_len", h_len[4] === 4'd3);
      chk("t4_next_trunc", h_trunc[4] === 1'b0);

      // Last flag exactly on the MAXB-th byte is not a truncation.
      for (int i = 0; i < MAXB; i++) q_byte(8'($urandom), (i == MAXB - 1), 0);
      send_queued();
      wait_done(6);
      chk("t5_len", h_len[5] === 4'd10);
      chk("t5_trunc", h_trunc[5] === 1'b0);

      // Two frames with the source always valid.
      q_byte(8'hC3, 1'b0, 0);
      q_byte(8'h3C, 1'b0, 0);
      q_byte(8'h7E, 1'b1, 0);
      q_byte(8'h81, 1'b0, 0);
      q_byte(8'hFF, 1'b1, 0);
      send_queued();
      wait_done(8);
      chk("t6_b2b_gap", (acc_q[3] - acc_q[2]) == (25 + IFG));

      // Reset at bit 3 of byte 2 aborts the frame.
      put_byte(8'h31, 1'b0, 0, a);
      put_byte(8'h32, 1'b0, 0, a);
      repeat (3) @(posedge CLK);
      #1;
      RST        = 1'b1;
      Data_Valid = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk("midframe_reset_outputs", {Data_Ready, FCS_Enable, FCS_Data, FCS_Cnt_done, Ser_Out,
                                     Ser_Valid, Frame_Done, Frame_Fcs, Frame_Len,
                                     Frame_Trunc} === 28'h0);
      @(posedge CLK);
      #1 RST = 1'b0;
      repeat (120) @(posedge CLK);
      #1;
      chk("abort_no_done", done_cnt == 8);
      q_check_string(0);
      send_queued();
      wait_done(9);
      chk("t7_fcs", h_fcs[8] === 16'h31C3);

      // Randomised frames, lengths spanning the truncation limit, random source stalls.
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(1, 12);
         lst = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < len; i++)
            q_byte(8'($urandom), lst && (i == len - 1),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0);
         send_queued();
      end
      put_byte(8'hA5, 1'b1, 0, a);
      Data_Valid = 1'b0;
      Data_Last  = 1'b0;
      n = 0;
      while ((exp_fcs.size() > 0 || exp_bits.size() > 0) && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      chk("drain", (exp_fcs.size() == 0) && (exp_bits.size() == 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fcs_frame_tx_ctrl.md
Name: fcs_frame_tx_ctrl

Overview:
Transmit-side sequencer for the serial CRC-16 FCS engine (poly x^16+x^12+x^5+1, MSB-first, init 0, no final XOR).
- Accepts frame bytes over a valid/ready handshake and serialises them MSB-first onto the line.
- Drives the engine's Enable / Input_Data / Cnt_done controls, then appends the 16-bit FCS to the serial stream and inserts an inter-frame gap.
- Sits between the byte-wide frame source and the serial line driver; the FCS engine is a sibling instance, not instantiated inside this block.

Parameters:
- MAX_BYTES, 256: maximum payload bytes per frame. Any byte accepted at this count is forced last.
- LEN_WIDTH, 9: width of Frame_Len. Must satisfy 2^LEN_WIDTH > MAX_BYTES.
- IFG_CYCLES, 12: idle cycles after the last FCS bit before the next byte can be accepted. Must be at least 1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- Data_In  in  8  payload byte.
- Data_Valid  in  1  Data_In is valid.
- Data_Last  in  1  qualifies Data_In as the final payload byte.
- Data_Ready  out  1  byte accepted when Data_Valid && Data_Ready.
- FCS_In  in  16  engine remainder.
- FCS_Enable  out  1  engine Enable.
- FCS_Data  out  1  engine Input_Data.
- FCS_Cnt_done  out  1  engine Cnt_done (hold).
- Ser_Out  out  1  serial line bit.
- Ser_Valid  out  1  Ser_Out carries a frame bit.
- Frame_Done  out  1  one-cycle completion pulse.
- Frame_Fcs  out  16  FCS of the last completed frame.
- Frame_Len  out  LEN_WIDTH  byte count of the last completed frame.
- Frame_Trunc  out  1  last frame hit MAX_BYTES without Data_Last (valid with Frame_Done).

Behaviour:
- Reset (synchronous, RST=1 at the CLK edge):
  - state=IDLE; all counters and shift registers cleared.
  - All outputs 0, including Frame_Fcs and Frame_Len.
  - Reset mid-frame aborts the frame with no Frame_Done. FCS_Enable=0 clears the engine on the next edge.
- Engine contract, per cycle:
  - Enable=0: engine clears.
  - Enable=1 and Cnt_done=0: engine shifts in FCS_Data.
  - Enable=1 and Cnt_done=1: engine holds.
- States: IDLE, DATA, WAIT, FCS, GAP.
- IDLE:
  - Data_Ready=1, FCS_Enable=0, Ser_Valid=0.
  - On accept: load byte into shift register, set bit_cnt=0, latch last flag, set byte_cnt=1, go to DATA.
- DATA:
  - Ser_Out = FCS_Data = shreg[7]; Ser_Valid=1; FCS_Enable=1; FCS_Cnt_done=0.
  - Shift left every cycle; bit_cnt increments.
  - Data_Ready=1 only when bit_cnt==7 and last flag clear.
  - At bit_cnt==7:
    - accept → reload, byte_cnt+1, stay in DATA (no bubble);
    - else last flag set → FCS;
    - else → WAIT.
- WAIT (source underrun):
  - Data_Ready=1, Ser_Valid=0, FCS_Enable=1, FCS_Cnt_done=1 (engine holds).
  - On accept → DATA with the same load rules as IDLE, byte_cnt+1.
- Last flag:
  - Set when (Data_Last) or (byte_cnt+1 == MAX_BYTES) at accept.
  - Frame_Trunc source is latched as (byte_cnt+1 == MAX_BYTES) && !Data_Last.
- FCS:
  - FCS_Enable=1, FCS_Cnt_done=1 (engine holds the final remainder).
  - fcs_cnt runs 0..15; Ser_Out = FCS_In[15-fcs_cnt]; FCS_Data=0; Ser_Valid=1; Data_Ready=0.
  - At fcs_cnt==15 → GAP, and in the same cycle register Frame_Fcs<=FCS_In, Frame_Len<=byte_cnt, Frame_Trunc<=latched flag.
- GAP:
  - FCS_Enable=0 (engine clears), Ser_Valid=0, Data_Ready=0.
  - Frame_Done=1 in the first GAP cycle only.
  - After IFG_CYCLES cycles → IDLE.
- Latency:
  - N back-to-back bytes → 8N+16 consecutive Ser_Valid cycles; the first bit appears the cycle after the first accept.
  - Frame_Done pulses 8N+17 cycles after the first accept, plus any WAIT cycles.
- Boundaries:
  - Data_Valid during FCS or GAP is ignored; the source holds its byte.
  - Data_Last on the first byte gives a single-byte frame.
  - byte_cnt never exceeds MAX_BYTES.

Decomposition:
- Shared package fcs_pkg holds:
  - state enum (IDLE, DATA, WAIT, FCS, GAP);
  - FCS_WIDTH=16, BYTE_WIDTH=8;
  - CRC-16 check constants 16'h31C3 and 16'h1021.
- One natural sub-module, fcs_gap_timer: a loadable down-counter with a done flag for the IFG. Everything else stays in a single FSM/datapath module.

Test Plan:
- Bytes "123456789" (0x31..0x39) back-to-back, Data_Last on 0x39 → 72 data bits, then serial FCS bits 0x31C3 MSB-first; Frame_Fcs=16'h31C3, Frame_Len=9, Frame_Trunc=0, Frame_Done at cycle 89 after the first accept.
- Single byte 0x01 with Data_Last → Ser_Out 00000001 then 0x1021 MSB-first; Frame_Len=1.
- Same as "123456789" but Data_Valid dropped for 5 cycles after byte 4 → 5 WAIT cycles with Ser_Valid=0; Frame_Fcs still 16'h31C3; Frame_Done delayed by 5 cycles.
- MAX_BYTES=4, 6 bytes of 0x00 without Data_Last → after 32 data bits, 16 FCS bits of 0; Frame_Len=4, Frame_Trunc=1; the 5th byte is held until GAP ends.
- RST=1 at bit 3 of byte 2 → next cycle: IDLE, all outputs 0, no Frame_Done. A following "123456789" frame → Frame_Fcs=16'h31C3.
- Two frames back-to-back with the source always valid → exactly IFG_CYCLES cycles of Data_Ready=0 / Ser_Valid=0 between the last FCS bit and the next accept.
